debug_uart_tx: RTL
==================

# debug_uart_tx

Serial transmitter for the CPU debug ports. It snapshots the seven 8-bit `debug_portN` buses and sends them to the host serial-port debugger as one framed UART packet (8N1, LSB first). It sits at the top level beside `cpu` and drives the board's TX pin. It is the sending end of the link whose receiving end is the host debugger.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is ≥ 2.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

Ports:
- `clk`  input  1  — the single clock. All state changes on its rising edge.
- `nreset`  input  1  — asynchronous, active-low reset.
- `capture`  input  1  — request to snapshot and send a frame. Sampled every rising edge.
- `debug_port1`..`debug_port7`  input  8 each  — payload bytes 1..7.
- `tx`  output  1  — UART serial line. Idle level is high.
- `busy`  output  1  — high while a frame is in flight.
- `frame_done`  output  1  — one-cycle pulse when a frame completes.

## Operation
- Frame byte order: `SYNC_BYTE`, then `debug_port1` … `debug_port7`, then (if enabled) the checksum byte.
- Each byte is sent as: start bit (0), data bits 0..7, stop bit (1). Every bit lasts exactly `CLKS_PER_BIT` cycles.
- Bytes are sent back to back. The next start bit follows the previous stop bit immediately, with no idle gap.
- Capture is accepted when `capture`=1 and `busy`=0 at a rising edge. On acceptance, all seven ports are latched into a payload register.
  - Port changes after acceptance do not affect the frame.
  - `capture` while `busy`=1 is ignored. It is not queued.
- State machine:
  - IDLE → START on accepted capture.
  - START → DATA after 1 bit time.
  - DATA → STOP after 8 bit times. The bit index runs 0..7.
  - STOP → START if more bytes remain; otherwise STOP → IDLE.
- Counters:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits. Counts 0..`CLKS_PER_BIT`-1, then wraps to 0 and advances the bit.
  - Bit index: 3 bits.
  - Byte index: 4 bits. Counts 0..LAST, where LAST = 7 without checksum and 8 with checksum.
- Byte select: a mux from the byte index. Index 0 selects `SYNC_BYTE`, 1..7 select the payload, 8 selects the checksum.
- `tx` is driven from a register (glitch-free). It equals 1 in IDLE and STOP, 0 in START, and the selected data bit in DATA.

## Timing
- Reset values, applied immediately when `nreset` falls: `tx`=1, `busy`=0, `frame_done`=0, state IDLE, all counters 0, payload register 0.
- Reset mid-frame: the frame is abandoned, `tx` returns high at once, and no frame_done pulse is produced. After `nreset` rises, nothing is sent until a new capture.
- If capture is accepted at edge E:
  - From E, `tx`=0 and `busy`=1.
  - The start bit occupies cycles E..E+`CLKS_PER_BIT`-1.
- Frame length F = (LAST+1) × 10 × `CLKS_PER_BIT` cycles.
- At edge E+F:
  - state is IDLE, `busy`=0, and `frame_done`=1 for exactly one cycle.
  - `tx` stays 1.
- A capture sampled at edge E+F is not accepted, because `busy` was still 1 at that edge. The earliest re-capture edge is E+F+1. The minimum inter-frame idle is therefore one cycle.
- Latency from capture to the first sync data bit is `CLKS_PER_BIT` cycles.

## Configuration
- Macro: `DEBUG_TX_CHECKSUM_EN`.
- Defined:
  - A ninth byte is appended, equal to the XOR of payload bytes 1..7 (sync byte excluded).
  - LAST = 8, and F = 90 × `CLKS_PER_BIT`.
- Undefined:
  - The checksum logic and byte 8 are not compiled in.
  - LAST = 7, and F = 80 × `CLKS_PER_BIT`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
1. **Reset.** Hold `nreset`=0 for 3 cycles → `tx`=1, `busy`=0, `frame_done`=0 throughout. After release with `capture`=0 for 50 cycles → `tx` stays 1.
2. **Basic frame.** Set ports to 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40 and pulse `capture` → a bench UART decoder sampling mid-bit receives A5 01 02 04 08 10 20 40. With the checksum enabled it also receives 7F.
3. **Frame length.** Measure from the capture edge to the `frame_done` pulse → 360 cycles with checksum, 320 without. `busy` is high for exactly that span, and `frame_done` is high for 1 cycle.
4. **Snapshot and ignored capture.** Start a frame with all ports at 0x55. During the frame, change all ports to 0xAA and hold `capture`=1 → the frame carries 0x55 only. After `frame_done`, with `capture` still high, a second frame starts at the next edge carrying 0xAA.
5. **Reset mid-frame.** Drop `nreset` during bit 3 of byte 2 → `tx`=1 and `busy`=0 within the same cycle, with no `frame_done`. After release, the line stays idle until a new capture, which then produces a full correct frame.
6. **Back-to-back bytes.** Check every stop-to-start boundary inside a frame → the stop bit is exactly 4 cycles high, followed immediately by a 4-cycle start bit with no extra idle cycle.

Source files
------------

// File: rtl/debug_uart_tx.sv
// Snapshots the seven debug ports and sends them as one 8N1 UART frame, LSB first.
// Define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte of payload bytes 1..7.
module debug_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       capture,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd8;
`else
    localparam logic [3:0] LAST_BYTE = 4'd7;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_bit_idx;
    logic [3:0]         r_byte_idx;
    logic [7:0]         r_payload [1:7];
    logic               r_tx;
    logic               r_busy;
    logic               r_frame_done;

    logic [7:0]         w_ports [1:7];
    logic [7:0]         w_cur_byte;
    logic               w_baud_wrap;

    assign w_ports[1] = debug_port1;
    assign w_ports[2] = debug_port2;
    assign w_ports[3] = debug_port3;
    assign w_ports[4] = debug_port4;
    assign w_ports[5] = debug_port5;
    assign w_ports[6] = debug_port6;
    assign w_ports[7] = debug_port7;

    assign w_baud_wrap = (r_baud == BAUD_MAX);

`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0] w_checksum;
    always_comb begin
        w_checksum = 8'h00;
        for (int i = 1; i <= 7; i++) begin
            w_checksum = w_checksum ^ r_payload[i];
        end
    end
`endif

    always_comb begin
        w_cur_byte = SYNC_BYTE;
        case (r_byte_idx)
            4'd1:    w_cur_byte = r_payload[1];
            4'd2:    w_cur_byte = r_payload[2];
            4'd3:    w_cur_byte = r_payload[3];
            4'd4:    w_cur_byte = r_payload[4];
            4'd5:    w_cur_byte = r_payload[5];
            4'd6:    w_cur_byte = r_payload[6];
            4'd7:    w_cur_byte = r_payload[7];
`ifdef DEBUG_TX_CHECKSUM_EN
            4'd8:    w_cur_byte = w_checksum;
`endif
            default: w_cur_byte = SYNC_BYTE;
        endcase
    end

    // tx is loaded one edge ahead of each bit so the line changes only on bit boundaries.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= 3'd0;
            r_byte_idx   <= 4'd0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 1; i <= 7; i++) begin
                r_payload[i] <= 8'h00;
            end
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (capture) begin
                        r_payload  <= w_ports;
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_baud     <= '0;
                        r_bit_idx  <= 3'd0;
                        r_byte_idx <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                        r_tx      <= w_cur_byte[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (r_byte_idx == LAST_BYTE) begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_byte_idx   <= 4'd0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_state    <= S_START;
                            r_tx       <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
